// File: rtl/fm_rmw_client.sv
`timescale 1ns/1ps
// fm_rmw_client
// Read/modify/write engine for the feature-map BRAM arbiter's read and write
// ports. Each command carries a coordinate and one signed delta per channel.
// The engine reads the stored word, adds the deltas per channel, and writes
// the result back. Results wait in a small FIFO until the write port grants.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_coord = {x,y}, cmd_delta packed
//                       with channel i at [i*B +: B]
//   read_req, coord_get read port request and coordinate (read_ready = grant)
//   read_data           read port data, valid READ_LATENCY cycles after read_req
//   write_req, coord_wtr, write_data
//                       write port request, coordinate and data (write_ready = grant)
//   busy                any command in the read pipeline or the result FIFO
//
// Build option:
//   FM_RMW_SAT_EN  defined   -> per-channel add saturates to the signed range
//                  undefined -> per-channel add wraps modulo 2^B
module fm_rmw_client #(
    parameter int COORD_BITS       = 8,
    parameter int CHANNELS         = 4,
    parameter int BITS_PER_CHANNEL = 8,
    parameter int READ_LATENCY     = 1,
    parameter int RES_DEPTH        = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [2*COORD_BITS-1:0]              cmd_coord,
    input  logic [CHANNELS*BITS_PER_CHANNEL-1:0] cmd_delta,
    output logic                                 read_req,
    output logic [2*COORD_BITS-1:0]              coord_get,
    input  logic [CHANNELS*BITS_PER_CHANNEL-1:0] read_data,
    input  logic                                 read_ready,
    output logic                                 write_req,
    output logic [2*COORD_BITS-1:0]              coord_wtr,
    output logic [CHANNELS*BITS_PER_CHANNEL-1:0] write_data,
    input  logic                                 write_ready,
    output logic                                 busy
);
    localparam int CW = 2*COORD_BITS;
    localparam int B  = BITS_PER_CHANNEL;
    localparam int DW = CHANNELS*BITS_PER_CHANNEL;
    localparam int L  = READ_LATENCY;
    localparam int D  = RES_DEPTH;
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int NW = $clog2(D+1);

    logic          pipe_v     [L];
    logic [CW-1:0] pipe_coord [L];
    logic [DW-1:0] pipe_delta [L];

    logic          fifo_v     [D];
    logic [CW-1:0] fifo_coord [D];
    logic [DW-1:0] fifo_data  [D];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] fifo_count;

    logic [NW-1:0] occ;
    logic          hazard, accept, push, pop;
    logic [DW-1:0] sum;
    logic [B-1:0]  ch_old, ch_delta;
`ifdef FM_RMW_SAT_EN
    logic [B:0]    ch_wide;
`endif

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(D-1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy and RAW hazard against every coordinate still owed a write.
    always_comb begin
        occ    = '0;
        hazard = 1'b0;
        for (int unsigned i = 0; i < L; i++) begin
            occ = occ + NW'(pipe_v[i]);
            if (pipe_v[i] && pipe_coord[i] == cmd_coord) hazard = 1'b1;
        end
        for (int unsigned j = 0; j < D; j++) begin
            if (fifo_v[j] && fifo_coord[j] == cmd_coord) hazard = 1'b1;
        end
    end

    // A credit is reserved per in-flight read so returning data always fits.
    assign cmd_ready = !rst && read_ready && ((occ + fifo_count) < NW'(D)) && !hazard;
    assign accept    = cmd_valid && cmd_ready;
    assign read_req  = accept;
    assign coord_get = accept ? cmd_coord : '0;

    assign push       = pipe_v[L-1];
    assign write_req  = (fifo_count != '0);
    assign pop        = write_req && write_ready;
    assign coord_wtr  = write_req ? fifo_coord[rd_ptr] : '0;
    assign write_data = write_req ? fifo_data[rd_ptr]  : '0;
    assign busy       = (occ != '0) || (fifo_count != '0);

    // Per-channel signed add of returning read data and the stored delta.
    always_comb begin
        sum      = '0;
        ch_old   = '0;
        ch_delta = '0;
`ifdef FM_RMW_SAT_EN
        ch_wide  = '0;
`endif
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            ch_old   = read_data[c*B +: B];
            ch_delta = pipe_delta[L-1][c*B +: B];
`ifdef FM_RMW_SAT_EN
            ch_wide = {ch_old[B-1], ch_old} + {ch_delta[B-1], ch_delta};
            if (ch_wide[B] != ch_wide[B-1])
                sum[c*B +: B] = ch_wide[B] ? {1'b1, {(B-1){1'b0}}} : {1'b0, {(B-1){1'b1}}};
            else
                sum[c*B +: B] = ch_wide[B-1:0];
`else
            sum[c*B +: B] = ch_old + ch_delta;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < L; i++) begin
                pipe_v[i]     <= 1'b0;
                pipe_coord[i] <= '0;
                pipe_delta[i] <= '0;
            end
        end else begin
            pipe_v[0]     <= accept;
            pipe_coord[0] <= cmd_coord;
            pipe_delta[0] <= cmd_delta;
            for (int unsigned i = 1; i < L; i++) begin
                pipe_v[i]     <= pipe_v[i-1];
                pipe_coord[i] <= pipe_coord[i-1];
                pipe_delta[i] <= pipe_delta[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int unsigned j = 0; j < D; j++) begin
                fifo_v[j]     <= 1'b0;
                fifo_coord[j] <= '0;
                fifo_data[j]  <= '0;
            end
        end else begin
            if (pop) begin
                fifo_v[rd_ptr] <= 1'b0;
                rd_ptr         <= ptr_next(rd_ptr);
            end
            if (push) begin
                fifo_v[wr_ptr]     <= 1'b1;
                fifo_coord[wr_ptr] <= pipe_coord[L-1];
                fifo_data[wr_ptr]  <= sum;
                wr_ptr             <= ptr_next(wr_ptr);
            end
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_fm_rmw_client.sv
`timescale 1ns/1ps
// Directed bench for fm_rmw_client with a one-cycle-latency BRAM model.
module tb_fm_rmw_client;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_coord;
    logic [31:0] cmd_delta;
    logic        read_req, read_ready;
    logic [15:0] coord_get;
    logic [31:0] read_data;
    logic        write_req, write_ready;
    logic [15:0] coord_wtr;
    logic [31:0] write_data;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:65535];
    logic [31:0] rd_q;
    logic        pre_en;
    logic [15:0] pre_addr;
    logic [31:0] pre_data;
    logic [15:0] wq_coord [$];
    logic [31:0] wq_data  [$];

    always #5 clk = ~clk;

    fm_rmw_client #(
        .COORD_BITS(8), .CHANNELS(4), .BITS_PER_CHANNEL(8),
        .READ_LATENCY(1), .RES_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_coord(cmd_coord), .cmd_delta(cmd_delta),
        .read_req(read_req), .coord_get(coord_get),
        .read_data(read_data), .read_ready(read_ready),
        .write_req(write_req), .coord_wtr(coord_wtr),
        .write_data(write_data), .write_ready(write_ready),
        .busy(busy)
    );

    assign read_data = rd_q;

    // BRAM model: read data one cycle after read_req; writes land on grant.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q = '0;
            for (int i = 0; i < 65536; i++) mem[i] = '0;
        end else begin
            if (read_req) rd_q = mem[coord_get];
            if (write_req && write_ready) begin
                mem[coord_wtr] = write_data;
                wq_coord.push_back(coord_wtr);
                wq_data.push_back(write_data);
            end
            if (pre_en) mem[pre_addr] = pre_data;
        end
    end

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd_coord = '0; cmd_delta = '0;
        read_ready = 1'b0; write_ready = 1'b0; pre_en = 1'b0;
        pre_addr = '0; pre_data = '0;
        @(negedge clk); @(negedge clk);
        tests++; if ({read_req, write_req, busy, cmd_ready} !== 4'b0) begin
            fails++; $display("FAIL reset_flags: got %b expected 0000", {read_req, write_req, busy, cmd_ready}); end
        tests++; if ({coord_get, coord_wtr, write_data} !== 64'h0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0", {coord_get, coord_wtr, write_data}); end
        rst = 1'b0;
        @(negedge clk); #1;
        tests++; if (cmd_ready !== 1'b0) begin
            fails++; $display("FAIL ready_no_grant: got %b expected 0", cmd_ready); end
        read_ready = 1'b1; write_ready = 1'b1; #1;
        tests++; if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL ready_with_grant: got %b expected 1", cmd_ready); end
        tests++; if (busy !== 1'b0) begin
            fails++; $display("FAIL idle_busy: got %b expected 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_single;
        preload(16'h0305, 32'h281E140A);
        cmd_valid = 1'b1; cmd_coord = 16'h0305; cmd_delta = 32'h04030201; #1;
        tests++; if ({cmd_ready, read_req, coord_get} !== {2'b11, 16'h0305}) begin
            fails++; $display("FAIL single_accept: got %b%b %h expected 11 0305", cmd_ready, read_req, coord_get); end
        @(negedge clk); cmd_valid = 1'b0; #1;
        tests++; if (write_req !== 1'b0) begin
            fails++; $display("FAIL single_early_write: got %b expected 0", write_req); end
        @(negedge clk); #1;
        tests++; if ({write_req, coord_wtr} !== {1'b1, 16'h0305}) begin
            fails++; $display("FAIL single_write_coord: got %b %h expected 1 0305", write_req, coord_wtr); end
        tests++; if (write_data !== 32'h2C21160B) begin
            fails++; $display("FAIL single_write_data: got %h expected 2c21160b", write_data); end
        @(negedge clk); #1;
        tests++; if ({write_req, busy} !== 2'b00) begin
            fails++; $display("FAIL single_drain: got %b expected 00", {write_req, busy}); end
    endtask

    task automatic test_back_to_back;
        cmd_delta = 32'h01010101;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 3) begin cmd_valid = 1'b1; cmd_coord = 16'(16'h0101 + cyc); end
            else cmd_valid = 1'b0;
            #1;
            if (cyc < 3) begin
                tests++; if (cmd_ready !== 1'b1) begin
                    fails++; $display("FAIL b2b_accept%0d: got %b expected 1", cyc, cmd_ready); end
            end
            if (cyc >= 2 && cyc <= 4) begin
                tests++; if ({write_req, coord_wtr, write_data} !== {1'b1, 16'(16'h0101 + cyc - 2), 32'h01010101}) begin
                    fails++; $display("FAIL b2b_write%0d: got %b %h %h expected 1 %h 01010101",
                                      cyc - 2, write_req, coord_wtr, write_data, 16'(16'h0101 + cyc - 2)); end
            end
            if (cyc == 5) begin
                tests++; if (write_req !== 1'b0) begin
                    fails++; $display("FAIL b2b_end: got %b expected 0", write_req); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hazard;
        cmd_valid = 1'b1; cmd_coord = 16'h0202; cmd_delta = 32'h01010101; #1;
        tests++; if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL haz_first: got %b expected 1", cmd_ready); end
        @(negedge clk); #1;
        tests++; if (cmd_ready !== 1'b0) begin
            fails++; $display("FAIL haz_stall_pipe: got %b expected 0", cmd_ready); end
        @(negedge clk); #1;
        tests++; if ({cmd_ready, write_req} !== 2'b01) begin
            fails++; $display("FAIL haz_stall_fifo: got %b expected 01", {cmd_ready, write_req}); end
        @(negedge clk); #1;
        tests++; if ({cmd_ready, read_req} !== 2'b11) begin
            fails++; $display("FAIL haz_release: got %b expected 11", {cmd_ready, read_req}); end
        @(negedge clk); cmd_valid = 1'b0;
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        tests++; if (busy !== 1'b0) begin
            fails++; $display("FAIL haz_timeout: busy %b expected 0", busy); end
        tests++; if (mem[16'h0202] !== 32'h02020202) begin
            fails++; $display("FAIL haz_final: got %h expected 02020202", mem[16'h0202]); end
    endtask

    task automatic test_backpressure;
        int idx, acc, n0;
        idx = 0; acc = 0; n0 = wq_coord.size();
        write_ready = 1'b0; cmd_delta = 32'h00000001;
        for (int cyc = 0; cyc < 10; cyc++) begin
            cmd_valid = (idx < 6); cmd_coord = 16'(16'h0400 + idx); #1;
            if (cmd_valid && cmd_ready) begin acc++; idx++; end
            @(negedge clk);
        end
        #1;
        tests++; if (acc !== 4) begin
            fails++; $display("FAIL bp_accepts: got %0d expected 4", acc); end
        tests++; if (cmd_ready !== 1'b0) begin
            fails++; $display("FAIL bp_full_ready: got %b expected 0", cmd_ready); end
        write_ready = 1'b1; #1;
        tests++; if (cmd_ready !== 1'b0) begin
            fails++; $display("FAIL bp_release_ready: got %b expected 0", cmd_ready); end
        for (int cyc = 0; cyc < 30 && (idx < 6 || busy); cyc++) begin
            cmd_valid = (idx < 6); cmd_coord = 16'(16'h0400 + idx); #1;
            if (cmd_valid && cmd_ready) begin acc++; idx++; end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        tests++; if ((wq_coord.size() - n0) !== 6 || acc !== 6) begin
            fails++; $display("FAIL bp_totals: writes %0d accepts %0d expected 6 6", wq_coord.size() - n0, acc); end
        for (int k = 0; k < 6 && n0 + k < wq_coord.size(); k++) begin
            tests++; if (wq_coord[n0 + k] !== 16'(16'h0400 + k)) begin
                fails++; $display("FAIL bp_order%0d: got %h expected %h", k, wq_coord[n0 + k], 16'(16'h0400 + k)); end
        end
    endtask

    task automatic test_sat_and_reset;
        int n1;
        logic [31:0] exp;
`ifdef FM_RMW_SAT_EN
        exp = 32'h05FB807F;
`else
        exp = 32'h05FB7E82;
`endif
        preload(16'h0909, 32'h00008878);
        cmd_valid = 1'b1; cmd_coord = 16'h0909; cmd_delta = 32'h05FBF60A;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk); #1;
        tests++; if ({write_req, write_data} !== {1'b1, exp}) begin
            fails++; $display("FAIL sat_data: got %b %h expected 1 %h", write_req, write_data, exp); end
        @(negedge clk);
        write_ready = 1'b0; cmd_delta = 32'h00000001;
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_coord = 16'(16'h0A00 + k);
            @(negedge clk);
        end
        cmd_valid = 1'b0; #1;
        tests++; if ({busy, write_req} !== 2'b11) begin
            fails++; $display("FAIL rst_pre_busy: got %b expected 11", {busy, write_req}); end
        n1 = wq_coord.size();
        rst = 1'b1; #1;
        tests++; if ({write_req, busy, cmd_ready} !== 3'b000) begin
            fails++; $display("FAIL rst_mid: got %b expected 000", {write_req, busy, cmd_ready}); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0; write_ready = 1'b1;
        repeat (5) @(negedge clk);
        tests++; if (wq_coord.size() !== n1 || busy !== 1'b0 || write_req !== 1'b0) begin
            fails++; $display("FAIL rst_no_writes: writes %0d busy %b req %b expected 0 0 0",
                              wq_coord.size() - n1, busy, write_req); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_hazard;
        test_backpressure;
        test_sat_and_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
